condicionador_botoes: RTL and testbench

- Input-conditioning stage directly upstream of the game datapath/control unit in circuito_exp7.
- Takes the four raw `botoes` lines, synchronises and debounces them, and enforces press-then-release.
- Emits exactly one `jogada_valida` pulse per accepted one-hot press, with the registered `jogada` code.
- Multi-button presses are rejected via a `multipla` pulse, so the control unit never sees repeated or ambiguous plays.

---
 rtl/condicionador_botoes.sv | 143 ++++++++++++++
 tb/tb_condicionador_botoes.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - button synchroniser, debouncer and press-then-release filter
//
// Conditions the four raw button lines for the game control unit. It emits one
// jogada_valida pulse per accepted one-hot press, or one multipla pulse when a
// stable press has more than one button set.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-low reset
//   botoes[3:0]    raw asynchronous button lines, 1 = pressed
//   habilita       1 = new presses may be accepted
//   jogada_valida  one-cycle pulse, accepted one-hot press
//   jogada[3:0]    last accepted one-hot code, held until the next accepted press
//   multipla       one-cycle pulse, multi-button press rejected
//   botao_ativo    1 while a press or release is being processed
//   db_estado[3:0] current FSM state code
module condicionador_botoes #(
    parameter int DEBOUNCE = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic       jogada_valida,
    output logic [3:0] jogada,
    output logic       multipla,
    output logic       botao_ativo,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        OCIOSO         = 4'd0,
        FILTRA         = 4'd1,
        REGISTRA       = 4'd2,
        ESPERA         = 4'd3,
        FILTRA_SOLTURA = 4'd4
    } estado_t;

    // The entry edge into FILTRA/FILTRA_SOLTURA already counts as the first
    // stable sample, so the filters finish when cnt reaches DEBOUNCE-1.
    localparam logic [7:0] LIMITE = 8'(DEBOUNCE - 1);

    estado_t    estado, estado_prox;
    logic [3:0] s1, s2;
    logic [7:0] cnt, cnt_prox;
    logic [3:0] cand, cand_prox;
    logic [3:0] jogada_prox;
    logic       um_quente;

    assign um_quente = (cand != 4'd0) && ((cand & (cand - 4'd1)) == 4'd0);
    assign db_estado = estado;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1     <= 4'd0;
            s2     <= 4'd0;
            estado <= OCIOSO;
            cnt    <= 8'd0;
            cand   <= 4'd0;
            jogada <= 4'd0;
        end else begin
            s1     <= botoes;
            s2     <= s1;
            estado <= estado_prox;
            cnt    <= cnt_prox;
            cand   <= cand_prox;
            jogada <= jogada_prox;
        end
    end

    always_comb begin
        estado_prox   = estado;
        cnt_prox      = cnt;
        cand_prox     = cand;
        jogada_prox   = jogada;
        jogada_valida = 1'b0;
        multipla      = 1'b0;
        botao_ativo   = 1'b0;

        case (estado)
            OCIOSO: begin
                if (habilita && (s2 != 4'd0)) begin
                    cand_prox   = s2;
                    cnt_prox    = 8'd1;
                    estado_prox = FILTRA;
                end
            end

            FILTRA: begin
                botao_ativo = 1'b1;
                // Any change of the sampled value restarts from OCIOSO, which
                // picks up the new value as a fresh candidate on the next edge.
                if (!habilita || (s2 != cand)) begin
                    estado_prox = OCIOSO;
                    cnt_prox    = 8'd0;
                end else if (cnt == LIMITE) begin
                    estado_prox = REGISTRA;
                end else begin
                    cnt_prox = cnt + 8'd1;
                end
            end

            REGISTRA: begin
                botao_ativo = 1'b1;
                estado_prox = ESPERA;
                cnt_prox    = 8'd0;
                if (um_quente) begin
                    jogada_valida = 1'b1;
                    jogada_prox   = cand;
                end else begin
                    multipla = 1'b1;
                end
            end

            ESPERA: begin
                botao_ativo = 1'b1;
                if (s2 == 4'd0) begin
                    cnt_prox    = 8'd1;
                    estado_prox = FILTRA_SOLTURA;
                end else begin
                    cnt_prox = 8'd0;
                end
            end

            FILTRA_SOLTURA: begin
                botao_ativo = 1'b1;
                if (s2 != 4'd0) begin
                    estado_prox = ESPERA;
                    cnt_prox    = 8'd0;
                end else if (cnt == LIMITE) begin
                    estado_prox = OCIOSO;
                end else begin
                    cnt_prox = cnt + 8'd1;
                end
            end

            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - scoreboard bench for condicionador_botoes
module tb_condicionador_botoes;

    localparam int DB = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic       jogada_valida;
    logic [3:0] jogada;
    logic       multipla;
    logic       botao_ativo;
    logic [3:0] db_estado;

    typedef struct {
        int         edge_no;
        bit         multi;
        logic [3:0] code;
    } esperado_t;

    esperado_t  sb[$];
    esperado_t  atual;
    int         edge_n    = 0;
    int         n_checks  = 0;
    int         n_fails   = 0;
    logic [3:0] exp_jogada = 4'd0;
    bit         pend      = 1'b0;
    logic [3:0] pend_code = 4'd0;
    int         seq_limpa [7] = '{0, 0, 1, 2, 3, 4, 0};

    condicionador_botoes #(.DEBOUNCE(DB)) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .habilita      (habilita),
        .jogada_valida (jogada_valida),
        .jogada        (jogada),
        .multipla      (multipla),
        .botao_ativo   (botao_ativo),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_n++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic wait_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic espera_pulso(input int e, input bit m, input logic [3:0] c);
        sb.push_back('{edge_no: e, multi: m, code: c});
    endtask

    // Drives a press for 'hold' cycles, then releases and idles long enough
    // for the release filter to finish.
    task automatic press(input logic [3:0] code, input int hold);
        bit m;
        botoes = code;
        if (habilita && hold >= DB) begin
            m = ($countones(code) != 1);
            if (!m) exp_jogada = code;
            espera_pulso(edge_n + DB + 2, m, exp_jogada);
        end
        repeat (hold) wait_edge();
        botoes = 4'd0;
        repeat (DB + 4) wait_edge();
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (pend) begin
                check_eq("jogada_after_pulse", 32'(jogada), 32'(pend_code));
                pend = 1'b0;
            end
            if (jogada_valida === 1'b1 || multipla === 1'b1) begin
                check_eq("pulse_exclusive", 32'(jogada_valida & multipla), 0);
                if (sb.size() == 0) begin
                    check_eq("unexpected_pulse", 1, 0);
                end else begin
                    atual = sb.pop_front();
                    check_eq("pulse_edge", 32'(edge_n), 32'(atual.edge_no));
                    check_eq("pulse_kind", 32'(multipla), 32'(atual.multi));
                    pend      = 1'b1;
                    pend_code = atual.code;
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        habilita = 1'b1;
        botoes   = 4'b0100;

        // Reset with a button held
        wait_edge();
        wait_edge();
        check_eq("rst_valida", 32'(jogada_valida), 0);
        check_eq("rst_multipla", 32'(multipla), 0);
        check_eq("rst_ativo", 32'(botao_ativo), 0);
        check_eq("rst_estado", 32'(db_estado), 0);
        check_eq("rst_jogada", 32'(jogada), 0);
        reset = 1'b1;
        exp_jogada = 4'b0100;
        espera_pulso(edge_n + DB + 2, 1'b0, 4'b0100);
        repeat (6) wait_edge();
        botoes = 4'd0;
        repeat (DB + 4) wait_edge();
        check_eq("rst_idle_estado", 32'(db_estado), 0);

        // Clean press with state trace
        botoes = 4'b0010;
        exp_jogada = 4'b0010;
        espera_pulso(edge_n + DB + 2, 1'b0, 4'b0010);
        for (int i = 0; i < 7; i++) begin
            wait_edge();
            check_eq("clean_estado", 32'(db_estado), 32'(seq_limpa[i]));
            check_eq("clean_ativo", 32'(botao_ativo), 32'(seq_limpa[i] != 0));
            if (i == 2) botoes = 4'd0;
        end
        check_eq("clean_jogada", 32'(jogada), 32'(4'b0010));

        // Glitch shorter than the debounce window
        press(4'b1000, 1);
        check_eq("glitch_estado", 32'(db_estado), 0);
        check_eq("glitch_jogada", 32'(jogada), 32'(exp_jogada));

        // Multiple buttons
        press(4'b0011, 5);
        check_eq("multi_jogada", 32'(jogada), 32'(4'b0010));

        // Long hold
        press(4'b0001, 50);
        check_eq("hold_jogada", 32'(jogada), 32'(4'b0001));

        // Press while disabled, then enable while still held
        habilita = 1'b0;
        botoes   = 4'b0100;
        repeat (6) wait_edge();
        check_eq("gate_estado", 32'(db_estado), 0);
        check_eq("gate_ativo", 32'(botao_ativo), 0);
        habilita = 1'b1;
        exp_jogada = 4'b0100;
        espera_pulso(edge_n + DB, 1'b0, 4'b0100);
        repeat (5) wait_edge();
        botoes = 4'd0;
        repeat (DB + 4) wait_edge();
        check_eq("gate_jogada", 32'(jogada), 32'(4'b0100));

        // habilita falls while in REGISTRA
        botoes = 4'b1000;
        exp_jogada = 4'b1000;
        espera_pulso(edge_n + DB + 2, 1'b0, 4'b1000);
        repeat (DB + 2) wait_edge();
        check_eq("drop_registra", 32'(db_estado), 2);
        habilita = 1'b0;
        repeat (3) wait_edge();
        botoes = 4'd0;
        repeat (DB + 4) wait_edge();
        habilita = 1'b1;
        check_eq("drop_jogada", 32'(jogada), 32'(4'b1000));

        // Reset during FILTRA
        botoes = 4'b1000;
        repeat (3) wait_edge();
        check_eq("midrst_filtra", 32'(db_estado), 1);
        reset  = 1'b0;
        botoes = 4'd0;
        wait_edge();
        check_eq("midrst_estado", 32'(db_estado), 0);
        check_eq("midrst_ativo", 32'(botao_ativo), 0);
        check_eq("midrst_jogada", 32'(jogada), 0);
        exp_jogada = 4'd0;
        wait_edge();
        reset = 1'b1;
        repeat (10) wait_edge();

        check_eq("final_estado", 32'(db_estado), 0);
        check_eq("final_jogada", 32'(jogada), 32'(exp_jogada));
        check_eq("scoreboard_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
